// File: rtl/cp0_params.sv
// Shared CP0 definitions: register map, field layouts, exception codes and the WB-to-CP0 bus.
// Optional TLB register support is enabled with CP0_TLB_REGS_EN.
package cp0_params;

    localparam logic [31:0]  CP0_EXCEPTION_ENTRY = 32'hBFC0_0380;
    localparam int unsigned  HW_INT_WIDTH        = 6;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [2:0] SEL_DEFAULT  = 3'd0;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } cp0_cause_t;

    typedef struct packed {
        logic [4:0]  address_register;
        logic [2:0]  address_select;
        logic        write_enabled;
        logic [31:0] write_data;
        logic        exception_valid;
        logic        eret_flush;
        logic [4:0]  exception_code;
        logic [31:0] exception_address;
        logic        in_delay_slot;
        logic        is_address_fault;
        logic [31:0] badvaddr_value;
        logic        tlb_read;
        logic        tlb_write;
        logic        tlb_probe;
    } wb_to_cp0_bus_t;

`ifdef CP0_TLB_REGS_EN
    localparam logic [4:0]  REG_INDEX    = 5'd0;
    localparam logic [4:0]  REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0]  REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0]  REG_ENTRYHI  = 5'd10;
    localparam int unsigned TLB_INDEX_W  = 4;

    typedef struct packed {
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
    } tlb_entry_t;

    typedef struct packed {
        logic                   hit;
        logic [TLB_INDEX_W-1:0] index;
    } tlb_probe_t;
`endif

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI latches on Count==Compare.
module cp0_timer
    import cp0_params::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] write_data,
    output logic [31:0] count_value,
    output logic [31:0] compare_value,
    output logic        timer_int
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we) count_d = write_data;
        if (count_q == compare_q) ti_d = 1'b1;
        // Compare write acknowledges the timer and wins over a same-cycle match
        if (compare_we) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_value   = count_q;
    assign compare_value = compare_q;
    assign timer_int     = ti_q;

endmodule

// File: rtl/cp0_register_file.sv
// CP0 register file fed by write-back: mfc0/mtc0, exception/eret state, interrupt request.
// Define CP0_TLB_REGS_EN to add Index/EntryLo0/EntryLo1/EntryHi and the TLB ports.
module cp0_register_file
    import cp0_params::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY = CP0_EXCEPTION_ENTRY
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  wb_to_cp0_bus_t          wb_to_cp0_bus,
    input  logic [HW_INT_WIDTH-1:0] external_interrupt,
`ifdef CP0_TLB_REGS_EN
    input  tlb_entry_t              tlb_read_entry,
    input  tlb_probe_t              tlb_probe_result,
    output tlb_entry_t              tlb_write_entry,
`endif
    output logic [31:0]             read_data,
    output logic [31:0]             epc_value,
    output logic [31:0]             exception_target,
    output logic                    interrupt_pending,
    output logic                    status_exl
);

    wb_to_cp0_bus_t bus;
    logic exc_c, eret_c, mtc0_c;
    logic wr_status_c, wr_cause_c, wr_epc_c, wr_count_c, wr_compare_c;

    logic [7:0]              im_q, im_d;
    logic                    exl_q, exl_d, ie_q, ie_d;
    logic                    bd_q, bd_d;
    logic [4:0]              exc_code_q, exc_code_d;
    logic [1:0]              ip_sw_q, ip_sw_d;
    logic [HW_INT_WIDTH-1:0] ip_hw_q, ip_hw_d;
    logic [31:0]             epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic                    int_pend_q, int_pend_d;

    logic [31:0] count_value, compare_value;
    logic        timer_int;
    cp0_status_t status_c;
    cp0_cause_t  cause_c;

    assign bus    = wb_to_cp0_bus;
    assign exc_c  = bus.exception_valid & ~bus.eret_flush;
    assign eret_c = bus.eret_flush;
    // Any exception or eret in the same cycle squashes the mtc0
    assign mtc0_c = bus.write_enabled & ~bus.exception_valid & ~bus.eret_flush
                  & (bus.address_select == SEL_DEFAULT);

    assign wr_status_c  = mtc0_c & (bus.address_register == REG_STATUS);
    assign wr_cause_c   = mtc0_c & (bus.address_register == REG_CAUSE);
    assign wr_epc_c     = mtc0_c & (bus.address_register == REG_EPC);
    assign wr_count_c   = mtc0_c & (bus.address_register == REG_COUNT);
    assign wr_compare_c = mtc0_c & (bus.address_register == REG_COMPARE);

    cp0_timer u_timer (
        .clock         (clock),
        .reset_n       (reset_n),
        .count_we      (wr_count_c),
        .compare_we    (wr_compare_c),
        .write_data    (bus.write_data),
        .count_value   (count_value),
        .compare_value (compare_value),
        .timer_int     (timer_int)
    );

    always_comb begin
        status_c     = '0;
        status_c.bev = 1'b1;
        status_c.im  = im_q;
        status_c.exl = exl_q;
        status_c.ie  = ie_q;
        cause_c          = '0;
        cause_c.bd       = bd_q;
        cause_c.ti       = timer_int;
        cause_c.ip       = {ip_hw_q, ip_sw_q};
        cause_c.exc_code = exc_code_q;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_hw_d    = external_interrupt | {timer_int, {(HW_INT_WIDTH-1){1'b0}}};
        int_pend_d = ie_q & ~exl_q & |(cause_c.ip & im_q);
        if (wr_status_c) begin
            im_d  = bus.write_data[15:8];
            exl_d = bus.write_data[1];
            ie_d  = bus.write_data[0];
        end
        if (wr_cause_c) ip_sw_d = bus.write_data[9:8];
        if (wr_epc_c)   epc_d   = bus.write_data;
        if (exc_c) begin
            exl_d      = 1'b1;
            exc_code_d = bus.exception_code;
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = bus.in_delay_slot ? bus.exception_address - 32'd4 : bus.exception_address;
                bd_d  = bus.in_delay_slot;
            end
            if (bus.is_address_fault) badvaddr_d = bus.badvaddr_value;
        end
        if (eret_c) exl_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            int_pend_q <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            int_pend_q <= int_pend_d;
        end
    end

`ifdef CP0_TLB_REGS_EN
    logic [31:0] index_q, index_d, entry_hi_q, entry_hi_d;
    logic [31:0] entry_lo0_q, entry_lo0_d, entry_lo1_q, entry_lo1_d;

    always_comb begin
        index_d     = index_q;
        entry_hi_d  = entry_hi_q;
        entry_lo0_d = entry_lo0_q;
        entry_lo1_d = entry_lo1_q;
        if (mtc0_c) begin
            case (bus.address_register)
                REG_INDEX:    index_d     = {index_q[31], 31'(bus.write_data[TLB_INDEX_W-1:0])};
                REG_ENTRYHI:  entry_hi_d  = bus.write_data;
                REG_ENTRYLO0: entry_lo0_d = bus.write_data;
                REG_ENTRYLO1: entry_lo1_d = bus.write_data;
                default: ;
            endcase
        end
        if (bus.tlb_probe) index_d = {~tlb_probe_result.hit, 31'(tlb_probe_result.index)};
        if (bus.tlb_read) begin
            entry_hi_d  = tlb_read_entry.entry_hi;
            entry_lo0_d = tlb_read_entry.entry_lo0;
            entry_lo1_d = tlb_read_entry.entry_lo1;
        end
        if (exc_c && (bus.exception_code == EXC_TLBL || bus.exception_code == EXC_TLBS))
            entry_hi_d[31:13] = bus.badvaddr_value[31:13];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index_q     <= '0;
            entry_hi_q  <= '0;
            entry_lo0_q <= '0;
            entry_lo1_q <= '0;
        end else begin
            index_q     <= index_d;
            entry_hi_q  <= entry_hi_d;
            entry_lo0_q <= entry_lo0_d;
            entry_lo1_q <= entry_lo1_d;
        end
    end

    assign tlb_write_entry = bus.tlb_write ? {entry_hi_q, entry_lo0_q, entry_lo1_q} : '0;
`else
    logic unused_tlb_strobes;
    assign unused_tlb_strobes = ^{bus.tlb_read, bus.tlb_write, bus.tlb_probe};
`endif

    // mfc0 read port: combinational, pre-edge values
    always_comb begin
        read_data = '0;
        if (bus.address_select == SEL_DEFAULT) begin
            case (bus.address_register)
                REG_BADVADDR: read_data = badvaddr_q;
                REG_COUNT:    read_data = count_value;
                REG_COMPARE:  read_data = compare_value;
                REG_STATUS:   read_data = status_c;
                REG_CAUSE:    read_data = cause_c;
                REG_EPC:      read_data = epc_q;
`ifdef CP0_TLB_REGS_EN
                REG_INDEX:    read_data = index_q;
                REG_ENTRYLO0: read_data = entry_lo0_q;
                REG_ENTRYLO1: read_data = entry_lo1_q;
                REG_ENTRYHI:  read_data = entry_hi_q;
`endif
                default:      read_data = '0;
            endcase
        end
    end

    assign epc_value         = epc_q;
    assign exception_target  = EXCEPTION_ENTRY;
    assign interrupt_pending = int_pend_q;
    assign status_exl        = exl_q;

endmodule

// File: tb/tb_cp0_register_file.sv
// Self-checking bench for cp0_register_file: directed scenarios plus random traffic vs a behavioural model.
module tb_cp0_register_file;
    import cp0_params::*;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    wb_to_cp0_bus_t bus;
    logic [5:0]     ext;
    logic [31:0]    read_data, epc_value, exception_target;
    logic           interrupt_pending, status_exl;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [31:0] m_count, m_compare, m_epc, m_bad;
    logic        m_tick, m_ti, m_exl, m_ie, m_bd, m_pend;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;

    always #5 clock = ~clock;

    cp0_register_file dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_to_cp0_bus     (bus),
        .external_interrupt(ext),
        .read_data         (read_data),
        .epc_value         (epc_value),
        .exception_target  (exception_target),
        .interrupt_pending (interrupt_pending),
        .status_exl        (status_exl)
    );

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_epc = 0; m_bad = 0;
        m_tick = 0; m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_pend = 0;
        m_im = 0; m_ip = 0; m_code = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return 32'h0;
        case (r)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_code) << 2);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of architectural behaviour, computed from pre-edge state and inputs
    task automatic model_step();
        logic [4:0]  r;
        logic [31:0] wd;
        logic exc, er, wr;
        logic [31:0] n_count, n_compare, n_epc, n_bad;
        logic        n_ti, n_exl, n_ie, n_bd, n_pend;
        logic [7:0]  n_im, n_ip;
        logic [4:0]  n_code;
        r  = bus.address_register;
        wd = bus.write_data;
        er  = bus.eret_flush;
        exc = bus.exception_valid && !er;
        wr  = bus.write_enabled && !bus.exception_valid && !er && bus.address_select == 3'd0;
        n_count   = (wr && r == 5'd9) ? wd : m_count + (m_tick ? 32'd1 : 32'd0);
        n_compare = (wr && r == 5'd11) ? wd : m_compare;
        n_ti      = (wr && r == 5'd11) ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_ti);
        n_ip      = {ext[5] | m_ti, ext[4:0], (wr && r == 5'd13) ? wd[9:8] : m_ip[1:0]};
        n_pend    = m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
        n_im      = (wr && r == 5'd12) ? wd[15:8] : m_im;
        n_ie      = (wr && r == 5'd12) ? wd[0] : m_ie;
        n_exl     = er ? 1'b0 : exc ? 1'b1 : (wr && r == 5'd12) ? wd[1] : m_exl;
        n_epc     = (exc && !m_exl) ? (bus.in_delay_slot ? bus.exception_address - 32'd4 : bus.exception_address)
                  : (wr && r == 5'd14) ? wd : m_epc;
        n_bd      = (exc && !m_exl) ? bus.in_delay_slot : m_bd;
        n_code    = exc ? bus.exception_code : m_code;
        n_bad     = (exc && bus.is_address_fault) ? bus.badvaddr_value : m_bad;
        m_tick = !m_tick; m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_ip = n_ip;
        m_pend = n_pend; m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_epc = n_epc; m_bd = n_bd;
        m_code = n_code; m_bad = n_bad;
    endtask

    // Called between a posedge and the following negedge; checks read port, then outputs after the edge
    task automatic tick(input string name);
        logic [31:0] exp_rd;
        @(negedge clock);
        #1;
        exp_rd = m_read(bus.address_register, bus.address_select);
        total++;
        if (read_data !== exp_rd) begin
            bad++;
            $display("FAIL %s read_data(%0d,%0d): got %h expected %h", name,
                     bus.address_register, bus.address_select, read_data, exp_rd);
        end
        @(posedge clock);
        model_step();
        #1;
        total++;
        if (epc_value !== m_epc) begin
            bad++; $display("FAIL %s epc_value: got %h expected %h", name, epc_value, m_epc);
        end
        total++;
        if (status_exl !== m_exl) begin
            bad++; $display("FAIL %s status_exl: got %b expected %b", name, status_exl, m_exl);
        end
        total++;
        if (interrupt_pending !== m_pend) begin
            bad++; $display("FAIL %s interrupt_pending: got %b expected %b", name, interrupt_pending, m_pend);
        end
        total++;
        if (exception_target !== 32'hBFC0_0380) begin
            bad++; $display("FAIL %s exception_target: got %h expected bfc00380", name, exception_target);
        end
    endtask

    task automatic set_write(input logic [4:0] r, input logic [31:0] d);
        bus = '0;
        bus.write_enabled    = 1'b1;
        bus.address_register = r;
        bus.write_data       = d;
    endtask

    task automatic set_read(input logic [4:0] r);
        bus = '0;
        bus.address_register = r;
    endtask

    task automatic test_reset();
        bus = '0; ext = '0; reset_n = 1'b0;
        model_reset();
        bus.address_register = 5'd12;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        total++;
        if (read_data !== 32'h0040_0000) begin
            bad++; $display("FAIL reset_status: got %h expected 00400000", read_data);
        end
        total++;
        if (interrupt_pending !== 1'b0 || epc_value !== 32'h0 || status_exl !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got pend=%b epc=%h exl=%b expected 0/0/0",
                            interrupt_pending, epc_value, status_exl);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        set_read(5'd9);
        repeat (10) tick("count_run");
        total++;
        if (read_data !== 32'd5) begin
            bad++; $display("FAIL count_after_10: got %0d expected 5", read_data);
        end
    endtask

    task automatic test_timer();
        bit seen = 0;
        set_write(5'd11, 32'd20); tick("timer_wr_compare");
        set_write(5'd9, 32'd10);  tick("timer_wr_count");
        set_read(5'd13);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick("timer_wait");
            if (read_data[30] === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL timer_ti: got 0 expected 1 within 40 cycles");
        end
        set_write(5'd12, 32'h0000_8001); tick("timer_wr_status");
        set_read(5'd13); tick("timer_pend_wait");
        total++;
        if (interrupt_pending !== 1'b1) begin
            bad++; $display("FAIL timer_irq: got %b expected 1", interrupt_pending);
        end
        set_write(5'd11, 32'd1000); tick("timer_ack");
        set_read(5'd13); #1;
        total++;
        if (read_data[30] !== 1'b0) begin
            bad++; $display("FAIL timer_ti_clear: got %b expected 0", read_data[30]);
        end
        repeat (3) tick("timer_settle");
    endtask

    task automatic test_exception();
        bus = '0;
        bus.exception_valid = 1'b1; bus.exception_code = EXC_ADEL;
        bus.exception_address = 32'hBFC0_1004; bus.in_delay_slot = 1'b1;
        bus.is_address_fault = 1'b1; bus.badvaddr_value = 32'h0000_0003;
        tick("exc_first");
        set_read(5'd8); #1;
        total++;
        if (epc_value !== 32'hBFC0_1000 || status_exl !== 1'b1) begin
            bad++; $display("FAIL exc_epc_exl: got epc=%h exl=%b expected bfc01000/1", epc_value, status_exl);
        end
        total++;
        if (read_data !== 32'h3) begin
            bad++; $display("FAIL exc_badvaddr: got %h expected 00000003", read_data);
        end
        set_read(5'd13); #1;
        total++;
        if (read_data[31] !== 1'b1 || read_data[6:2] !== 5'd4) begin
            bad++; $display("FAIL exc_cause: got bd=%b code=%0d expected 1/4", read_data[31], read_data[6:2]);
        end
        tick("exc_hold");
        total++;
        if (interrupt_pending !== 1'b0) begin
            bad++; $display("FAIL exc_irq_masked: got %b expected 0", interrupt_pending);
        end
        bus = '0;
        bus.exception_valid = 1'b1; bus.exception_code = EXC_OV; bus.exception_address = 32'h100;
        tick("exc_nested");
        set_read(5'd13); #1;
        total++;
        if (epc_value !== 32'hBFC0_1000 || read_data[6:2] !== 5'd12) begin
            bad++; $display("FAIL exc_nested: got epc=%h code=%0d expected bfc01000/12", epc_value, read_data[6:2]);
        end
        bus = '0; bus.eret_flush = 1'b1; tick("eret");
        total++;
        if (status_exl !== 1'b0) begin
            bad++; $display("FAIL eret_exl: got %b expected 0", status_exl);
        end
        set_write(5'd14, 32'h0000_1234);
        bus.exception_valid = 1'b1; bus.exception_code = EXC_SYS; bus.exception_address = 32'h2000;
        tick("exc_vs_mtc0");
        total++;
        if (epc_value !== 32'h0000_2000) begin
            bad++; $display("FAIL exc_vs_mtc0: got %h expected 00002000", epc_value);
        end
        bus = '0; bus.eret_flush = 1'b1; tick("eret2");
    endtask

    task automatic test_ext_int();
        set_write(5'd12, 32'h0000_0401);
        ext = 6'b000001;
        tick("ext_wr_status");
        set_read(5'd13);
        repeat (2) tick("ext_wait");
        total++;
        if (read_data[10] !== 1'b1 || interrupt_pending !== 1'b1) begin
            bad++; $display("FAIL ext_irq: got ip10=%b pend=%b expected 1/1", read_data[10], interrupt_pending);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (interrupt_pending !== 1'b0 || epc_value !== 32'h0 || status_exl !== 1'b0 || read_data !== 32'h0) begin
            bad++; $display("FAIL mid_reset: got pend=%b epc=%h exl=%b cause=%h expected all 0",
                            interrupt_pending, epc_value, status_exl, read_data);
        end
        set_read(5'd12); #1;
        total++;
        if (read_data !== 32'h0040_0000) begin
            bad++; $display("FAIL mid_reset_status: got %h expected 00400000", read_data);
        end
        ext = '0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
        int r;
        for (int i = 0; i < 400; i++) begin
            bus = '0;
            r = $urandom_range(0, 99);
            bus.address_register = ($urandom_range(0, 9) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
            bus.address_select   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
            if (r < 35) begin
                bus.write_enabled = 1'b1;
                bus.write_data = 32'($urandom);
                if (bus.address_register == 5'd11 && r < 20)
                    bus.write_data = m_count + 32'($urandom_range(0, 6));
            end else if (r < 45) begin
                bus.exception_valid = 1'b1;
            end else if (r < 50) begin
                bus.eret_flush = 1'b1;
                bus.exception_valid = 1'($urandom);
            end
            if (r >= 35 && r < 50) bus.write_enabled = 1'($urandom);
            bus.write_data        = bus.write_enabled && bus.write_data == 0 ? 32'($urandom) : bus.write_data;
            bus.exception_code    = 5'($urandom);
            bus.exception_address = 32'($urandom);
            bus.in_delay_slot     = 1'($urandom);
            bus.is_address_fault  = 1'($urandom);
            bus.badvaddr_value    = 32'($urandom);
            bus.tlb_read          = 1'($urandom);
            bus.tlb_write         = 1'($urandom);
            bus.tlb_probe         = 1'($urandom);
            if ($urandom_range(0, 7) == 0) ext = 6'($urandom);
            tick("random");
        end
    endtask

    initial begin
        bus = '0;
        ext = '0;
        test_reset();
        test_timer();
        test_exception();
        test_ext_int();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
